// File: rtl/r2sdf_fft_stream.sv
// Streaming radix-2 single-path delay-feedback FFT (decimation in frequency).
// Bins leave in bit-reversed order, scaled by 1/N, tagged with their natural index.
module r2sdf_fft_stream #(
    parameter int LOG2N = 3,
    parameter int DW    = 16,
    parameter int TW    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 flush,
    input  logic                 inverse,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    output logic                 out_valid,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im,
    output logic [LOG2N-1:0]     out_idx,
    output logic                 out_last
);
    localparam int N  = 1 << LOG2N;
    localparam int SW = 2 * DW + 2;  // {valid, mode, re, im}
    localparam real PI = 3.14159265358979323846;
    localparam logic signed [DW+TW:0] RND = {{(DW+2){1'b0}}, 1'b1, {(TW-2){1'b0}}};

    // Twiddle component for angle 2*pi*k/N, Taylor series, rounded and clipped to Q1.(TW-1).
    function automatic int tw_val(input int k, input bit want_cos);
        real th, x2, term, acc, v;
        int  r;
        int  lim;
        th = 2.0 * PI * k / N;
        x2 = th * th;
        if (want_cos) begin
            term = 1.0;
            acc  = 1.0;
            for (int unsigned i = 1; i <= 16; i++) begin
                term = -term * x2 / ((2 * i - 1) * (2 * i));
                acc  = acc + term;
            end
        end else begin
            term = th;
            acc  = th;
            for (int unsigned i = 1; i <= 16; i++) begin
                term = -term * x2 / ((2 * i) * (2 * i + 1));
                acc  = acc + term;
            end
        end
        v   = acc * (2.0 ** (TW - 1));
        r   = $rtoi(v + ((v >= 0.0) ? 0.5 : -0.5));
        lim = (1 << (TW - 1)) - 1;
        if (r > lim)  r = lim;
        if (r < -lim) r = -lim;
        return r;
    endfunction

    // Advance edge at which sample index 0 of a frame reaches stage s.
    function automatic int stage_delay(input int s);
        int d;
        d = 0;
        for (int unsigned t = 1; t < s; t++) d = d + (N >> t) + 1;
        return d;
    endfunction

    function automatic logic signed [DW-1:0] scale_sat(input logic signed [DW+TW:0] v);
        logic signed [DW+TW:0] t;
        t = v >>> (TW - 1);
        if (t[DW+TW:DW-1] == '0 || t[DW+TW:DW-1] == '1)
            scale_sat = t[DW-1:0];
        else
            scale_sat = t[DW+TW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    endfunction

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        for (int unsigned i = 0; i < LOG2N; i++) bitrev[i] = v[LOG2N-1-i];
    endfunction

    logic             adv;
    logic [LOG2N-1:0] in_cnt;
    logic             mode_q;
    logic             in_mode;
    logic signed [DW-1:0] s_re, s_im;
    logic [SW-1:0]    st [LOG2N+1];

    assign adv = in_valid | flush;

    always_comb begin
        in_mode = (in_cnt == '0) ? inverse : mode_q;
        s_re    = in_valid ? in_re : '0;
        s_im    = in_valid ? in_im : '0;
    end

    assign st[0] = {in_valid, in_mode, s_re, s_im};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt <= '0;
            mode_q <= 1'b0;
        end else if (adv) begin
            in_cnt <= in_cnt + LOG2N'(1);
            if (in_cnt == '0) mode_q <= inverse;
        end
    end

    for (genvar s = 1; s <= LOG2N; s++) begin : g_stage
        localparam int L = N >> s;
        localparam int B = LOG2N - s + 1;

        logic [SW-1:0] dl [L];
        logic [SW-1:0] q, nxt, push;
        logic [B-1:0]  c;
        logic          va, ma, vb, mb;
        logic signed [DW-1:0] ar, ai, br, bi, hr, hi;
        logic [DW:0]   sr, si, dr, di;

        // Local position in the 2L cycle, derived from the shared input counter.
        assign c = B'(in_cnt - LOG2N'(stage_delay(s)));
        assign {va, ma, ar, ai} = dl[L-1];
        assign {vb, mb, br, bi} = st[s-1];
        assign sr = {ar[DW-1], ar} + {br[DW-1], br};
        assign si = {ai[DW-1], ai} + {bi[DW-1], bi};
        assign dr = {ar[DW-1], ar} - {br[DW-1], br};
        assign di = {ai[DW-1], ai} - {bi[DW-1], bi};

        if (L == 1) begin : g_last
            assign hr = ar;
            assign hi = ai;
        end else begin : g_mul
            logic signed [TW-1:0] rom_c [L];
            logic signed [TW-1:0] rom_s [L];
            logic signed [TW-1:0] wc, ws;
            logic signed [DW+TW-1:0] p0, p1, p2, p3;
            logic signed [DW+TW:0]   acc_re, acc_im;
            logic [B-2:0] k;

            for (genvar j = 0; j < L; j++) begin : g_rom
                localparam logic signed [TW-1:0] WC = TW'(tw_val(j << (s - 1), 1'b1));
                localparam logic signed [TW-1:0] WS = TW'(tw_val(j << (s - 1), 1'b0));
                assign rom_c[j] = WC;
                assign rom_s[j] = WS;
            end

            assign k  = c[B-2:0];
            assign wc = rom_c[k];
            assign ws = ma ? -rom_s[k] : rom_s[k];
            assign p0 = (DW+TW)'(ar) * (DW+TW)'(wc);
            assign p1 = (DW+TW)'(ai) * (DW+TW)'(ws);
            assign p2 = (DW+TW)'(ai) * (DW+TW)'(wc);
            assign p3 = (DW+TW)'(ar) * (DW+TW)'(ws);
            assign acc_re = (DW+TW+1)'(p0) + (DW+TW+1)'(p1) + RND;
            assign acc_im = (DW+TW+1)'(p2) - (DW+TW+1)'(p3) + RND;
            assign hr = scale_sat(acc_re);
            assign hi = scale_sat(acc_im);
        end

        always_comb begin
            nxt  = st[s-1];
            push = st[s-1];
            if (c[B-1]) begin
                nxt  = {vb, mb, sr[DW:1], si[DW:1]};
                push = {vb, mb, dr[DW:1], di[DW:1]};
            end else begin
                nxt  = {va, ma, hr, hi};
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= '0;
                for (int unsigned i = 0; i < L; i++) dl[i] <= '0;
            end else if (adv) begin
                q     <= nxt;
                dl[0] <= push;
                for (int unsigned i = 1; i < L; i++) dl[i] <= dl[i-1];
            end
        end

        assign st[s] = q;
    end

    logic [LOG2N-1:0] ocnt;
    logic             last_v;

    assign last_v = st[LOG2N][SW-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            ocnt      <= '0;
        end else begin
            out_valid <= adv & last_v;
            if (adv && last_v) begin
                out_re   <= st[LOG2N][2*DW-1:DW];
                out_im   <= st[LOG2N][DW-1:0];
                out_idx  <= bitrev(ocnt);
                out_last <= (ocnt == '1);
                ocnt     <= ocnt + LOG2N'(1);
            end
        end
    end
endmodule
